// File: rtl/tone_divider_pkg.sv
// Shared state encoding and default width for the tone divider.
package tone_divider_pkg;

    localparam int TONE_WIDTH = 25;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/tone_divider_downcounter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module tone_downcounter #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (ld) begin
            count <= ld_val;
        end else if (en && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tone_divider.sv
// Programmable square-wave generator; period changes take effect at half-period wraps.
//
//  state       | meaning
//  ST_IDLE     | tone low, counter held, waiting for enable and a non-zero period
//  ST_RUN      | counting half-periods, tone toggles at each wrap
//  ST_STOPPING | enable dropped while tone high; finish the high phase then idle
module tone_divider
    import tone_divider_pkg::*;
#(
    parameter int WIDTH = TONE_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    input  logic             enable,
    output logic             tone,
    output logic             tick,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] active, active_nxt;
    logic [WIDTH-1:0] pending, pending_nxt;
    logic             pend_v, pend_v_nxt;
    logic             tone_nxt, tick_nxt;
    logic [WIDTH-1:0] sel_period;
    logic             cnt_ld, cnt_en, cnt_zero;
    logic [WIDTH-1:0] cnt_ld_val, cnt_count;

    tone_downcounter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .ld     (cnt_ld),
        .ld_val (cnt_ld_val),
        .en     (cnt_en),
        .count  (cnt_count),
        .zero   (cnt_zero)
    );

    // A load in the same cycle beats the queued value, which beats the current one.
    assign sel_period = load ? period : (pend_v ? pending : active);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            active  <= '0;
            pending <= '0;
            pend_v  <= 1'b0;
            tone    <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nxt;
            active  <= active_nxt;
            pending <= pending_nxt;
            pend_v  <= pend_v_nxt;
            tone    <= tone_nxt;
            tick    <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        active_nxt  = active;
        pending_nxt = pending;
        pend_v_nxt  = pend_v;
        tone_nxt    = tone;
        tick_nxt    = 1'b0;
        cnt_ld      = 1'b0;
        cnt_ld_val  = '0;
        cnt_en      = 1'b0;

        if (load) begin
            pending_nxt = period;
            pend_v_nxt  = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                active_nxt = sel_period;
                pend_v_nxt = 1'b0;
                tone_nxt   = 1'b0;
                if (enable && (sel_period != '0)) begin
                    state_nxt  = ST_RUN;
                    tone_nxt   = 1'b1;
                    cnt_ld     = 1'b1;
                    cnt_ld_val = sel_period - ONE;
                end
            end
            ST_RUN, ST_STOPPING: begin
                cnt_en = 1'b1;
                if (enable) begin
                    state_nxt = ST_RUN;
                    if (cnt_zero) begin
                        active_nxt = sel_period;
                        pend_v_nxt = 1'b0;
                        tick_nxt   = tone;
                        if (sel_period == '0) begin
                            tone_nxt  = 1'b0;
                            state_nxt = ST_IDLE;
                        end else begin
                            tone_nxt   = ~tone;
                            cnt_ld     = 1'b1;
                            cnt_ld_val = sel_period - ONE;
                        end
                    end
                end else if (!tone) begin
                    state_nxt = ST_IDLE;
                end else begin
                    // Let the high phase finish so the output never shows a runt pulse.
                    state_nxt = ST_STOPPING;
                    if (cnt_zero) begin
                        tone_nxt  = 1'b0;
                        tick_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tone_nxt  = 1'b0;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_tone_divider.sv
// Directed bench for tone_divider: expected tone/tick/busy sequences written per clock.
module tb_tone_divider;
    import tone_divider_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  load;
    logic [TONE_WIDTH-1:0] period;
    logic                  enable;
    logic                  tone, tick, busy;

    int checks = 0;
    int errors = 0;

    tone_divider #(.WIDTH(TONE_WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .period (period),
        .enable (enable),
        .tone   (tone),
        .tick   (tick),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // One character per clock: expected tone, tick and busy sampled 1 ns after each edge.
    task automatic steps(input string tag, input string et, input string ek, input string eb);
        for (int i = 0; i < et.len(); i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].tone", tag, i), tone, et[i] == "1");
            chk($sformatf("%s[%0d].tick", tag, i), tick, ek[i] == "1");
            chk($sformatf("%s[%0d].busy", tag, i), busy, eb[i] == "1");
        end
    endtask

    initial begin
        reset  = 1'b0;
        load   = 1'b0;
        period = '0;
        enable = 1'b0;
        #12;
        chk("rst.tone", tone, 1'b0);
        chk("rst.tick", tick, 1'b0);
        chk("rst.busy", busy, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // period 3: 3 high, 3 low, tick at each high->low
        load = 1'b1; period = 25'd3;
        steps("t1_load", "0", "0", "0");
        load = 1'b0; enable = 1'b1;
        steps("t1_run", "1110001110", "0001000001", "1111111111");
        steps("t1_tail", "001", "000", "111");

        // load 5 during high phase: current phase stays 3
        load = 1'b1; period = 25'd5;
        steps("t2_load", "1", "0", "1");
        load = 1'b0;
        steps("t2_run", "100000111110", "010000000001", "111111111111");

        // load 7 on the wrap cycle bypasses into the next phase
        steps("t3_pre", "0000", "0000", "1111");
        load = 1'b1; period = 25'd7;
        steps("t3_wrap", "1", "0", "1");
        load = 1'b0;
        steps("t3_run", "1111110", "0000001", "1111111");

        // load 4 then 6 before the wrap: 6 wins
        load = 1'b1; period = 25'd4;
        steps("t3_ld4", "0", "0", "1");
        period = 25'd6;
        steps("t3_ld6", "0", "0", "1");
        load = 1'b0;
        steps("t3_run6", "00001111110", "00000000001", "11111111111");

        // drop enable while high: finish high phase, tick, then idle
        steps("t4_pre", "000001", "000000", "111111");
        enable = 1'b0;
        steps("t4_stop", "1111100", "0000010", "1111100");

        // drop enable while low: idle next cycle, no tick
        enable = 1'b1;
        steps("t4_rerun", "1111110", "0000001", "1111111");
        enable = 1'b0;
        steps("t4_lowstop", "00", "00", "00");

        // period 1: toggle every cycle, tick every other
        enable = 1'b1; load = 1'b1; period = 25'd1;
        steps("t5_start", "1", "0", "1");
        load = 1'b0;
        steps("t5_run", "0101", "1010", "1111");
        // period 0 loaded while high: silence at the wrap, tick still fires
        load = 1'b1; period = 25'd0;
        steps("t5_zero", "0", "1", "0");
        load = 1'b0;
        steps("t5_idle", "00", "00", "00");

        // async reset mid-run
        load = 1'b1; period = 25'd4;
        steps("t6_start", "1", "0", "1");
        load = 1'b0;
        steps("t6_run", "11", "00", "11");
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async.tone", tone, 1'b0);
        chk("t6_async.tick", tick, 1'b0);
        chk("t6_async.busy", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("t6_held.tone", tone, 1'b0);
        chk("t6_held.busy", busy, 1'b0);
        #2;
        reset = 1'b1;
        steps("t6_wait", "0", "0", "0");
        load = 1'b1;
        steps("t6_restart", "1", "0", "1");
        load = 1'b0;
        steps("t6_run2", "1110", "0001", "1111");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
